ucsbece154b_perf_monitor: RTL and testbench



---
 rtl/ucsbece154b_perf_monitor.sv | 123 ++++++++++++
 tb/tb_ucsbece154b_perf_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_perf_monitor.sv
// Cycle/instruction counter with halt (both fetch slots parked on a NOP) and timeout detection.
// Moore outputs: status and counts appear the cycle after the deciding edge; no backpressure.
module ucsbece154b_perf_monitor #(
   parameter int          CNT_WIDTH  = 32,
   parameter logic [31:0] NOP_ENC    = 32'h0000_0013,
   parameter int          MAX_CYCLES = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic [31:0]          pcf1_i,
   input  logic [31:0]          pcf2_i,
   input  logic [31:0]          instrf1_i,
   input  logic [31:0]          instrf2_i,
   input  logic [31:0]          instrd1_i,
   input  logic [31:0]          instrd2_i,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic [CNT_WIDTH-1:0] instr_count_o,
   output logic                 running_o,
   output logic                 done_o,
   output logic                 timeout_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cycle_cnt, cycle_nxt;
   logic [CNT_WIDTH-1:0] instr_cnt, instr_nxt;
   logic [31:0]          prev_pc1, prev_pc1_nxt;
   logic [31:0]          prev_pc2, prev_pc2_nxt;
   logic                 prev_valid, prev_valid_nxt;
   logic                 timeout_q, timeout_nxt;

   logic                 slot1_useful, slot2_useful;
   logic [1:0]           useful_n;
   logic [CNT_WIDTH:0]   instr_sum;
   logic [CNT_WIDTH-1:0] instr_sat, cycle_sat;
   logic                 halt_cond;

   assign slot1_useful = (instrd1_i != 32'd0) && (instrd1_i != NOP_ENC);
   assign slot2_useful = (instrd2_i != 32'd0) && (instrd2_i != NOP_ENC);
   assign useful_n     = {1'b0, slot1_useful} + {1'b0, slot2_useful};

   // One extra adder bit exposes the carry so the counter pins at all-ones instead of wrapping.
   assign instr_sum = {1'b0, instr_cnt} + (CNT_WIDTH + 1)'(useful_n);
   assign instr_sat = instr_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : instr_sum[CNT_WIDTH-1:0];
   assign cycle_sat = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);

   assign halt_cond = prev_valid
                    && (prev_pc1 == pcf1_i) && (instrf1_i == NOP_ENC)
                    && (prev_pc2 == pcf2_i) && (instrf2_i == NOP_ENC);

   always_comb begin
      state_nxt      = state;
      cycle_nxt      = cycle_cnt;
      instr_nxt      = instr_cnt;
      prev_pc1_nxt   = prev_pc1;
      prev_pc2_nxt   = prev_pc2;
      prev_valid_nxt = prev_valid;
      timeout_nxt    = timeout_q;
      if (clear_i) begin
         state_nxt      = IDLE;
         cycle_nxt      = '0;
         instr_nxt      = '0;
         prev_pc1_nxt   = '0;
         prev_pc2_nxt   = '0;
         prev_valid_nxt = 1'b0;
         timeout_nxt    = 1'b0;
      end else begin
         case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
               if (halt_cond) begin
                  // Halt outranks the budget edge and leaves the counters untouched.
                  state_nxt   = DONE;
                  timeout_nxt = 1'b0;
               end else begin
                  cycle_nxt      = cycle_sat;
                  instr_nxt      = instr_sat;
                  prev_pc1_nxt   = pcf1_i;
                  prev_pc2_nxt   = pcf2_i;
                  prev_valid_nxt = 1'b1;
                  if (cycle_cnt == LAST_CYCLE) begin
                     state_nxt   = DONE;
                     timeout_nxt = 1'b1;
                  end
               end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cycle_cnt  <= '0;
         instr_cnt  <= '0;
         prev_pc1   <= '0;
         prev_pc2   <= '0;
         prev_valid <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cycle_cnt  <= cycle_nxt;
         instr_cnt  <= instr_nxt;
         prev_pc1   <= prev_pc1_nxt;
         prev_pc2   <= prev_pc2_nxt;
         prev_valid <= prev_valid_nxt;
         timeout_q  <= timeout_nxt;
      end
   end

   assign cycle_count_o = cycle_cnt;
   assign instr_count_o = instr_cnt;
   assign running_o     = (state == RUN);
   assign done_o        = (state == DONE);
   assign timeout_o     = (state == DONE) && timeout_q;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench for the perf monitor: default build plus a 4-bit/15-cycle build for saturation.
module tb_ucsbece154b_perf_monitor;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] VI  = 32'h0050_0413;

   logic        clk = 1'b0;
   logic        reset, reset2, clear;
   logic [31:0] pcf1, pcf2, instrf1, instrf2, instrd1, instrd2;
   logic [31:0] pc;

   logic [31:0] cyc_a, ins_a;
   logic        run_a, done_a, to_a;
   logic [3:0]  cyc_b, ins_b;
   logic        run_b, done_b, to_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ucsbece154b_perf_monitor dut (
      .clk(clk), .reset(reset), .clear_i(clear),
      .pcf1_i(pcf1), .pcf2_i(pcf2), .instrf1_i(instrf1), .instrf2_i(instrf2),
      .instrd1_i(instrd1), .instrd2_i(instrd2),
      .cycle_count_o(cyc_a), .instr_count_o(ins_a),
      .running_o(run_a), .done_o(done_a), .timeout_o(to_a)
   );

   ucsbece154b_perf_monitor #(.CNT_WIDTH(4), .MAX_CYCLES(15)) dut_sat (
      .clk(clk), .reset(reset2), .clear_i(1'b0),
      .pcf1_i(pcf1), .pcf2_i(pcf2), .instrf1_i(instrf1), .instrf2_i(instrf2),
      .instrd1_i(VI), .instrd2_i(VI),
      .cycle_count_o(cyc_b), .instr_count_o(ins_b),
      .running_o(run_b), .done_o(done_b), .timeout_o(to_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each counted cycle presents fresh, never-repeating PCs so no accidental halt.
   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) begin
         pc      = pc + 32'd8;
         pcf1    = pc;
         pcf2    = pc + 32'd4;
         instrf1 = VI;
         instrf2 = VI;
         tick();
      end
   endtask

   task automatic park_nop();
      pcf1    = 32'h40;
      pcf2    = 32'h44;
      instrf1 = NOP;
      instrf2 = NOP;
      tick();
   endtask

   task automatic restart();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      run_n(1);
   endtask

   initial begin
      reset = 1'b1; reset2 = 1'b1; clear = 1'b0;
      pc = 32'h1000; pcf1 = pc; pcf2 = pc + 32'd4;
      instrf1 = VI; instrf2 = VI; instrd1 = VI; instrd2 = VI;
      tick(); tick();
      chk("rst_cycle", cyc_a, 0);
      chk("rst_instr", ins_a, 0);
      chk("rst_running", {31'd0, run_a}, 0);
      chk("rst_done", {31'd0, done_a}, 0);
      chk("rst_timeout", {31'd0, to_a}, 0);

      // Release reset; IDLE absorbs one edge, then ten dual-issue cycles.
      reset = 1'b0;
      run_n(1);
      chk("idle_absorb_cycle", cyc_a, 0);
      chk("idle_absorb_running", {31'd0, run_a}, 1);
      run_n(10);
      chk("run10_cycle", cyc_a, 10);
      chk("run10_instr", ins_a, 20);
      chk("run10_running", {31'd0, run_a}, 1);
      chk("run10_done", {31'd0, done_a}, 0);

      // Clear mid-RUN returns to IDLE with zeroed counts.
      clear = 1'b1;
      tick();
      chk("clr_run_cycle", cyc_a, 0);
      chk("clr_run_instr", ins_a, 0);
      chk("clr_run_running", {31'd0, run_a}, 0);
      clear = 1'b0;
      run_n(1);

      // Mixed decode slots: 1+1+0+2+0+1 = 5 useful.
      instrd1 = VI;  instrd2 = 32'd0; run_n(1);
      instrd1 = NOP; instrd2 = VI;    run_n(1);
      instrd1 = 0;   instrd2 = 32'd0; run_n(1);
      instrd1 = VI;  instrd2 = VI;    run_n(1);
      instrd1 = NOP; instrd2 = NOP;   run_n(1);
      instrd1 = VI;  instrd2 = NOP;   run_n(1);
      chk("mixed_instr", ins_a, 5);
      chk("mixed_cycle", cyc_a, 6);
      instrd1 = VI; instrd2 = VI;

      // Halt: four counted cycles, first parked edge still counts, second halts.
      restart();
      run_n(4);
      park_nop();
      chk("park1_cycle", cyc_a, 5);
      chk("park1_done", {31'd0, done_a}, 0);
      park_nop();
      chk("halt_done", {31'd0, done_a}, 1);
      chk("halt_timeout", {31'd0, to_a}, 0);
      chk("halt_cycle", cyc_a, 5);
      chk("halt_instr", ins_a, 10);
      chk("halt_running", {31'd0, run_a}, 0);
      run_n(5);
      chk("halt_frozen_cycle", cyc_a, 5);
      chk("halt_frozen_done", {31'd0, done_a}, 1);

      // Clear out of DONE, then run to the cycle budget.
      clear = 1'b1;
      tick();
      chk("clr_done_cycle", cyc_a, 0);
      chk("clr_done_done", {31'd0, done_a}, 0);
      chk("clr_done_running", {31'd0, run_a}, 0);
      clear = 1'b0;
      run_n(1);
      chk("resume_running", {31'd0, run_a}, 1);
      run_n(199);
      chk("pre_budget_cycle", cyc_a, 199);
      chk("pre_budget_done", {31'd0, done_a}, 0);
      run_n(1);
      chk("budget_cycle", cyc_a, 200);
      chk("budget_instr", ins_a, 400);
      chk("budget_done", {31'd0, done_a}, 1);
      chk("budget_timeout", {31'd0, to_a}, 1);
      park_nop();
      run_n(3);
      chk("budget_frozen_cycle", cyc_a, 200);
      chk("budget_frozen_timeout", {31'd0, to_a}, 1);

      // Halt on the budget edge wins over timeout.
      restart();
      run_n(198);
      park_nop();
      chk("edge_park_cycle", cyc_a, 199);
      park_nop();
      chk("edge_halt_done", {31'd0, done_a}, 1);
      chk("edge_halt_timeout", {31'd0, to_a}, 0);
      chk("edge_halt_cycle", cyc_a, 199);

      // Asynchronous reset between edges.
      restart();
      run_n(3);
      chk("pre_arst_cycle", cyc_a, 3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_cycle", cyc_a, 0);
      chk("arst_instr", ins_a, 0);
      chk("arst_running", {31'd0, run_a}, 0);
      tick();
      reset = 1'b0;
      run_n(1);
      chk("post_arst_running", {31'd0, run_a}, 1);
      chk("post_arst_cycle", cyc_a, 0);

      // Narrow build: 14 cycles of two useful slots saturate at 15, budget hits at 15.
      chk("sat_rst_instr", {28'd0, ins_b}, 0);
      reset2 = 1'b0;
      run_n(1);
      run_n(7);
      chk("sat_mid_instr", {28'd0, ins_b}, 14);
      run_n(7);
      chk("sat_pre_cycle", {28'd0, cyc_b}, 14);
      chk("sat_pre_instr", {28'd0, ins_b}, 15);
      chk("sat_pre_done", {31'd0, done_b}, 0);
      run_n(1);
      chk("sat_cycle", {28'd0, cyc_b}, 15);
      chk("sat_instr", {28'd0, ins_b}, 15);
      chk("sat_done", {31'd0, done_b}, 1);
      chk("sat_timeout", {31'd0, to_b}, 1);
      chk("sat_running", {31'd0, run_b}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
